// File: rtl/ibex_arb_pkg.sv
// Shared types for the Ibex OBI-to-Avalon arbiter: source IDs, FSM states
// and the Avalon command bundle.
package ibex_arb_pkg;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } arb_src_e;

   typedef enum logic {
      ARB_IDLE,
      ARB_HOLD
   } arb_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        read;
      logic        write;
      logic [3:0]  be;
      logic [31:0] wdata;
   } avm_cmd_t;

endpackage

// File: rtl/ibex_arb_src_fifo.sv
// In-order FIFO of source IDs for accepted-but-unanswered Avalon commands.
// Depth must be a power of two so the pointers wrap naturally.
module ibex_arb_src_fifo
   import ibex_arb_pkg::*;
#(
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  arb_src_e        push_src_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o,
   output arb_src_e        head_o
);

   arb_src_e        mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            wr_en, rd_en;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // a pop while full frees its slot only from the next cycle
   assign wr_en = push_i & ~full_o;
   assign rd_en = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_src_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ibex_obi_avalon_arb.sv
// Merges Ibex instruction and data OBI ports onto one pipelined Avalon-MM host.
// Optional error reporting from avm_response_i is enabled by IBEX_ARB_RESP_ERR_EN.
module ibex_obi_avalon_arb
   import ibex_arb_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic [31:0] avm_address_o,
   output logic        avm_read_o,
   output logic        avm_write_o,
   output logic [3:0]  avm_byteenable_o,
   output logic [31:0] avm_writedata_o,
   input  logic        avm_waitrequest_i,
   input  logic [31:0] avm_readdata_i,
   input  logic        avm_readdatavalid_i,
   input  logic        avm_writeresponsevalid_i,
   input  logic [1:0]  avm_response_i
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   arb_state_e      state_q;
   arb_src_e        last_src_q, hold_src_q, sel, fifo_head;
   avm_cmd_t        hold_cmd_q, instr_cmd, data_cmd, cmd;
   logic            present, accept, resp_valid, pop;
   logic            fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_count;

   always_comb begin
      instr_cmd = '{addr: instr_addr_i, read: 1'b1, write: 1'b0, be: 4'hF, wdata: '0};
      data_cmd  = '{addr: data_addr_i, read: ~data_we_i, write: data_we_i,
                    be: data_be_i, wdata: data_wdata_i};
      sel       = SRC_INSTR;
      present   = 1'b0;
      cmd       = instr_cmd;
      if (state_q == ARB_HOLD) begin
         // replay the latched command so nothing on avm_* moves while stalled
         sel     = hold_src_q;
         present = 1'b1;
         cmd     = hold_cmd_q;
      end else begin
         if (instr_req_i && data_req_i)
            sel = (last_src_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
         else if (data_req_i)
            sel = SRC_DATA;
         present = (instr_req_i | data_req_i) & ~fifo_full;
         cmd     = (sel == SRC_DATA) ? data_cmd : instr_cmd;
      end
   end

   assign accept           = present & ~avm_waitrequest_i;
   assign avm_address_o    = cmd.addr;
   assign avm_read_o       = present & cmd.read;
   assign avm_write_o      = present & cmd.write;
   assign avm_byteenable_o = cmd.be;
   assign avm_writedata_o  = cmd.wdata;
   assign instr_gnt_o      = accept & (sel == SRC_INSTR);
   assign data_gnt_o       = accept & (sel == SRC_DATA);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB_IDLE;
         last_src_q <= SRC_DATA;
         hold_src_q <= SRC_INSTR;
         hold_cmd_q <= '0;
      end else begin
         if (accept) last_src_q <= sel;
         case (state_q)
            ARB_IDLE: begin
               if (present && avm_waitrequest_i) begin
                  state_q    <= ARB_HOLD;
                  hold_src_q <= sel;
                  hold_cmd_q <= cmd;
               end
            end
            ARB_HOLD: begin
               if (!avm_waitrequest_i) state_q <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   ibex_arb_src_fifo #(
      .Depth (MaxOutstanding)
   ) u_src_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (accept),
      .push_src_i (sel),
      .pop_i      (pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count),
      .head_o     (fifo_head)
   );

   assign resp_valid     = avm_readdatavalid_i | avm_writeresponsevalid_i;
   assign pop            = resp_valid & ~fifo_empty;
   assign instr_rvalid_o = pop & (fifo_head == SRC_INSTR);
   assign data_rvalid_o  = pop & (fifo_head == SRC_DATA);
   assign instr_rdata_o  = avm_readdata_i;
   assign data_rdata_o   = avm_readdata_i;

`ifdef IBEX_ARB_RESP_ERR_EN
   assign instr_err_o = instr_rvalid_o & (avm_response_i != 2'b00);
   assign data_err_o  = data_rvalid_o & (avm_response_i != 2'b00);
`else
   logic unused_response;
   assign unused_response = ^avm_response_i;
   assign instr_err_o     = 1'b0;
   assign data_err_o      = 1'b0;
`endif

   a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(resp_valid && fifo_empty));
   a_single_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(avm_readdatavalid_i && avm_writeresponsevalid_i));
   a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      fifo_count <= CntW'(MaxOutstanding));

endmodule

// File: tb/tb_ibex_obi_avalon_arb.sv
// Directed self-checking bench for ibex_obi_avalon_arb (MaxOutstanding = 4).
module tb_ibex_obi_avalon_arb;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic [31:0] avm_address_o, avm_writedata_o, avm_readdata_i;
   logic        avm_read_o, avm_write_o, avm_waitrequest_i;
   logic [3:0]  avm_byteenable_o;
   logic        avm_readdatavalid_i, avm_writeresponsevalid_i;
   logic [1:0]  avm_response_i;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   ibex_obi_avalon_arb #(.MaxOutstanding(4)) dut (
      .clk_i                    (clk_i),
      .rst_ni                   (rst_ni),
      .instr_req_i              (instr_req_i),
      .instr_addr_i             (instr_addr_i),
      .instr_gnt_o              (instr_gnt_o),
      .instr_rvalid_o           (instr_rvalid_o),
      .instr_rdata_o            (instr_rdata_o),
      .instr_err_o              (instr_err_o),
      .data_req_i               (data_req_i),
      .data_we_i                (data_we_i),
      .data_be_i                (data_be_i),
      .data_addr_i              (data_addr_i),
      .data_wdata_i             (data_wdata_i),
      .data_gnt_o               (data_gnt_o),
      .data_rvalid_o            (data_rvalid_o),
      .data_rdata_o             (data_rdata_o),
      .data_err_o               (data_err_o),
      .avm_address_o            (avm_address_o),
      .avm_read_o               (avm_read_o),
      .avm_write_o              (avm_write_o),
      .avm_byteenable_o         (avm_byteenable_o),
      .avm_writedata_o          (avm_writedata_o),
      .avm_waitrequest_i        (avm_waitrequest_i),
      .avm_readdata_i           (avm_readdata_i),
      .avm_readdatavalid_i      (avm_readdatavalid_i),
      .avm_writeresponsevalid_i (avm_writeresponsevalid_i),
      .avm_response_i           (avm_response_i)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      instr_req_i = 1'b0; instr_addr_i = '0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
      avm_waitrequest_i = 1'b0; avm_readdata_i = '0;
      avm_readdatavalid_i = 1'b0; avm_writeresponsevalid_i = 1'b0; avm_response_i = 2'b00;
   endtask

   task automatic test_reset();
      logic [7:0] outs;
      #1;
      outs = {avm_read_o, avm_write_o, instr_gnt_o, data_gnt_o,
              instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o};
      total++;
      if (outs !== 8'h00) begin
         bad++; $display("FAIL reset_outputs: got %b expected 00000000", outs);
      end
   endtask

   // Both ports request continuously from reset: expect I,D,I,D, then routed responses.
   task automatic test_round_robin();
      instr_req_i = 1'b1; instr_addr_i = 32'h20;
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h10;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if ({instr_gnt_o, data_gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", i,
                            {instr_gnt_o, data_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         total++;
         if (avm_address_o !== ((i % 2 == 0) ? 32'h20 : 32'h10)) begin
            bad++; $display("FAIL rr_addr[%0d]: got %h", i, avm_address_o);
         end
         step();
      end
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         avm_readdatavalid_i = (i % 2 == 0);
         avm_writeresponsevalid_i = (i % 2 == 1);
         #1;
         total++;
         if ({instr_rvalid_o, data_rvalid_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr_resp[%0d]: got %b", i, {instr_rvalid_o, data_rvalid_o});
         end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_basic();
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
      data_addr_i = 32'h1000; data_wdata_i = 32'h1234_5678;
      #1;
      total++;
      if ({avm_write_o, avm_read_o, data_gnt_o, instr_gnt_o} !== 4'b1010) begin
         bad++; $display("FAIL basic_wr_cmd: got %b expected 1010",
                         {avm_write_o, avm_read_o, data_gnt_o, instr_gnt_o});
      end
      total++;
      if ({avm_address_o, avm_byteenable_o, avm_writedata_o} !== {32'h1000, 4'h3, 32'h1234_5678}) begin
         bad++; $display("FAIL basic_wr_fields: got %h %h %h", avm_address_o, avm_byteenable_o, avm_writedata_o);
      end
      step();
      clear_inputs();
      avm_writeresponsevalid_i = 1'b1;
      #1;
      total++;
      if ({data_rvalid_o, instr_rvalid_o} !== 2'b10) begin
         bad++; $display("FAIL basic_wr_resp: got %b expected 10", {data_rvalid_o, instr_rvalid_o});
      end
      step();
      clear_inputs();
      instr_req_i = 1'b1; instr_addr_i = 32'h80;
      #1;
      total++;
      if ({avm_read_o, avm_write_o, instr_gnt_o, avm_byteenable_o, avm_address_o} !== {3'b101, 4'hF, 32'h80}) begin
         bad++; $display("FAIL basic_rd_cmd: got %b %h %h", {avm_read_o, avm_write_o, instr_gnt_o},
                         avm_byteenable_o, avm_address_o);
      end
      step();
      clear_inputs();
      avm_readdatavalid_i = 1'b1; avm_readdata_i = 32'hDEAD_BEEF;
      #1;
      total++;
      if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
         bad++; $display("FAIL basic_rd_resp: got %b %h", {instr_rvalid_o, data_rvalid_o}, instr_rdata_o);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_hold();
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hC;
      data_addr_i = 32'h2000; data_wdata_i = 32'hA5A5_A5A5;
      avm_waitrequest_i = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         #1;
         total++;
         if ({avm_write_o, avm_read_o, instr_gnt_o, data_gnt_o, avm_address_o, avm_writedata_o}
             !== {4'b1000, 32'h2000, 32'hA5A5_A5A5}) begin
            bad++; $display("FAIL hold_cycle%0d: got %b %h %h", c,
                            {avm_write_o, avm_read_o, instr_gnt_o, data_gnt_o}, avm_address_o, avm_writedata_o);
         end
         step();
         instr_req_i = 1'b1; instr_addr_i = 32'h300;
      end
      avm_waitrequest_i = 1'b0;
      #1;
      total++;
      if ({data_gnt_o, instr_gnt_o, avm_write_o, avm_address_o} !== {3'b101, 32'h2000}) begin
         bad++; $display("FAIL hold_accept: got %b %h", {data_gnt_o, instr_gnt_o, avm_write_o}, avm_address_o);
      end
      step();
      data_req_i = 1'b0;
      #1;
      total++;
      if ({instr_gnt_o, avm_read_o, avm_address_o} !== {2'b11, 32'h300}) begin
         bad++; $display("FAIL hold_instr_after: got %b %h", {instr_gnt_o, avm_read_o}, avm_address_o);
      end
      step();
      clear_inputs();
      avm_writeresponsevalid_i = 1'b1;
      #1;
      total++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
         bad++; $display("FAIL hold_resp0: got %b expected 01", {instr_rvalid_o, data_rvalid_o});
      end
      step();
      clear_inputs();
      avm_readdatavalid_i = 1'b1;
      #1;
      total++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
         bad++; $display("FAIL hold_resp1: got %b expected 10", {instr_rvalid_o, data_rvalid_o});
      end
      step();
      clear_inputs();
   endtask

   // Fill with D,I,I,I; a 5th data read stalls until one response frees a slot.
   task automatic test_outstanding();
      for (int i = 0; i < 4; i++) begin
         instr_req_i = (i != 0); instr_addr_i = 32'h100 + i;
         data_req_i = (i == 0); data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h400;
         #1;
         total++;
         if ({instr_gnt_o, data_gnt_o} !== ((i == 0) ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL out_fill[%0d]: got %b", i, {instr_gnt_o, data_gnt_o});
         end
         step();
      end
      clear_inputs();
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h500;
      #1;
      total++;
      if ({data_gnt_o, avm_read_o, avm_write_o} !== 3'b000) begin
         bad++; $display("FAIL out_stall: got %b expected 000", {data_gnt_o, avm_read_o, avm_write_o});
      end
      step();
      avm_readdatavalid_i = 1'b1;
      #1;
      total++;
      if ({data_rvalid_o, instr_rvalid_o, data_gnt_o} !== 3'b100) begin
         bad++; $display("FAIL out_pop_no_bypass: got %b expected 100", {data_rvalid_o, instr_rvalid_o, data_gnt_o});
      end
      step();
      avm_readdatavalid_i = 1'b0;
      #1;
      total++;
      if ({data_gnt_o, avm_read_o, avm_address_o} !== {2'b11, 32'h500}) begin
         bad++; $display("FAIL out_fifth_accept: got %b %h", {data_gnt_o, avm_read_o}, avm_address_o);
      end
      step();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         avm_readdatavalid_i = 1'b1;
         #1;
         total++;
         if ({instr_rvalid_o, data_rvalid_o} !== ((i < 3) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL out_drain[%0d]: got %b", i, {instr_rvalid_o, data_rvalid_o});
         end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_interleaved();
      logic [3:0] order;
      order = 4'b1001;  // bit i set = instr for command i: I, D, D, I
      for (int i = 0; i < 4; i++) begin
         instr_req_i = order[i]; instr_addr_i = 32'h600;
         data_req_i = ~order[i]; data_we_i = (i == 2); data_be_i = 4'h1; data_addr_i = 32'h700;
         #1;
         total++;
         if ({instr_gnt_o, data_gnt_o} !== {order[i], ~order[i]}) begin
            bad++; $display("FAIL il_grant[%0d]: got %b", i, {instr_gnt_o, data_gnt_o});
         end
         step();
      end
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         avm_readdatavalid_i = (i != 2);
         avm_writeresponsevalid_i = (i == 2);
         avm_readdata_i = 32'hC0DE_0000 + i;
         #1;
         total++;
         if ({instr_rvalid_o, data_rvalid_o, data_rdata_o} !== {order[i], ~order[i], 32'hC0DE_0000 + i}) begin
            bad++; $display("FAIL il_resp[%0d]: got %b %h", i, {instr_rvalid_o, data_rvalid_o}, data_rdata_o);
         end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_error();
      logic exp_err;
`ifdef IBEX_ARB_RESP_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h40;
      step();
      clear_inputs();
      avm_readdatavalid_i = 1'b1; avm_response_i = 2'b10;
      #1;
      total++;
      if ({data_rvalid_o, data_err_o, instr_err_o} !== {1'b1, exp_err, 1'b0}) begin
         bad++; $display("FAIL err_data: got %b expected %b", {data_rvalid_o, data_err_o, instr_err_o},
                         {1'b1, exp_err, 1'b0});
      end
      step();
      clear_inputs();
      instr_req_i = 1'b1; instr_addr_i = 32'h44;
      step();
      clear_inputs();
      avm_readdatavalid_i = 1'b1; avm_response_i = 2'b00;
      #1;
      total++;
      if ({instr_rvalid_o, instr_err_o, data_err_o} !== 3'b100) begin
         bad++; $display("FAIL err_instr_ok: got %b expected 100", {instr_rvalid_o, instr_err_o, data_err_o});
      end
      step();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      logic [7:0] outs;
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h800;
      step();
      clear_inputs();
      instr_req_i = 1'b1; instr_addr_i = 32'h900;
      step();
      clear_inputs();
      rst_ni = 1'b0;
      avm_readdatavalid_i = 1'b1;
      #1;
      outs = {avm_read_o, avm_write_o, instr_gnt_o, data_gnt_o,
              instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o};
      total++;
      if (outs !== 8'h00) begin
         bad++; $display("FAIL rst_mid_outputs: got %b expected 00000000", outs);
      end
      step();
      avm_readdatavalid_i = 1'b0;
      step();
      rst_ni = 1'b1;
      instr_req_i = 1'b1; instr_addr_i = 32'hA00;
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'hB00;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if ({instr_gnt_o, data_gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rst_refill[%0d]: got %b", i, {instr_gnt_o, data_gnt_o});
         end
         step();
      end
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         avm_readdatavalid_i = (i % 2 == 0);
         avm_writeresponsevalid_i = (i % 2 == 1);
         #1;
         total++;
         if ({instr_rvalid_o, data_rvalid_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rst_drain[%0d]: got %b", i, {instr_rvalid_o, data_rvalid_o});
         end
         step();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_ni = 1'b0;
      test_reset();
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      test_round_robin();
      test_basic();
      test_hold();
      test_outstanding();
      test_interleaved();
      test_error();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
